// File: rtl/display_write_arbiter_if.sv
// Requester and hex-writer handshake bundle for display_write_arbiter.
// master: the arbiter; slave: requesters plus the display writer.
interface display_write_arbiter_if #(
    parameter int unsigned NUM_REQ = 2
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [16*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]    req_ack;
    logic                  hex_latch;
    logic [15:0]           hex_data;
    logic                  hex_busy;
    logic                  busy;
    logic [1:0]            owner;
    logic                  err_timeout;

    modport master (
        input  req_valid, req_data, hex_busy,
        output req_ack, hex_latch, hex_data, busy, owner, err_timeout
    );

    modport slave (
        output req_valid, req_data, hex_busy,
        input  req_ack, hex_latch, hex_data, busy, owner, err_timeout
    );
endinterface

// File: rtl/display_write_arbiter.sv
// Round-robin sharing of one TM1637 hex writer between NUM_REQ requesters,
// holding the granted value on hex_data and optionally re-writing it when idle.
module display_write_arbiter #(
    parameter int unsigned NUM_REQ        = 2,
    parameter int unsigned REFRESH_CYCLES = 0,
    parameter int unsigned START_TIMEOUT  = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    display_write_arbiter_if.master bus
);
    localparam logic [1:0] S_IDLE       = 2'd0;
    localparam logic [1:0] S_WAIT_START = 2'd1;
    localparam logic [1:0] S_WAIT_DONE  = 2'd2;

    logic [1:0]         state;
    logic [1:0]         last_grant;
    logic               have_value;
    logic [31:0]        refresh_cnt;
    logic [7:0]         start_cnt;

    logic               grant_found;
    logic [1:0]         grant_idx;
    logic [15:0]        grant_data;
    logic [NUM_REQ-1:0] grant_vec;
    logic               refresh_due;
    logic [3:0]         valid4;
    logic [63:0]        data4;

    // Requests are zero-padded to four slots so every select is a plain 2-bit index.
    always_comb begin
        int unsigned idx;
        idx         = 0;
        valid4      = 4'(bus.req_valid);
        data4       = 64'(bus.req_data);
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            idx = (32'(last_grant) + i) % NUM_REQ;
            if (!grant_found && valid4[2'(idx)]) begin
                grant_found = 1'b1;
                grant_idx   = 2'(idx);
            end
        end
        grant_data  = data4[{grant_idx, 4'b0000} +: 16];
        grant_vec   = (NUM_REQ)'(4'b0001 << grant_idx);
        refresh_due = (REFRESH_CYCLES != 0) && have_value &&
                      (refresh_cnt == REFRESH_CYCLES - 1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= S_IDLE;
            last_grant      <= 2'(NUM_REQ - 1);
            have_value      <= 1'b0;
            refresh_cnt     <= '0;
            start_cnt       <= '0;
            bus.req_ack     <= '0;
            bus.hex_latch   <= 1'b0;
            bus.hex_data    <= '0;
            bus.busy        <= 1'b0;
            bus.owner       <= '0;
            bus.err_timeout <= 1'b0;
        end else begin
            bus.hex_latch <= 1'b0;
            bus.req_ack   <= '0;
            case (state)
                S_IDLE: begin
                    // A live request always beats a refresh expiring on the same cycle.
                    if (!bus.hex_busy && grant_found) begin
                        bus.hex_data  <= grant_data;
                        bus.req_ack   <= grant_vec;
                        bus.hex_latch <= 1'b1;
                        bus.busy      <= 1'b1;
                        bus.owner     <= grant_idx;
                        last_grant    <= grant_idx;
                        have_value    <= 1'b1;
                        refresh_cnt   <= '0;
                        start_cnt     <= '0;
                        state         <= S_WAIT_START;
                    end else if (!bus.hex_busy && refresh_due) begin
                        bus.hex_latch <= 1'b1;
                        bus.busy      <= 1'b1;
                        refresh_cnt   <= '0;
                        start_cnt     <= '0;
                        state         <= S_WAIT_START;
                    end else if ((REFRESH_CYCLES != 0) && have_value) begin
                        refresh_cnt <= refresh_cnt + 32'd1;
                    end
                end
                S_WAIT_START: begin
                    if (bus.hex_busy) begin
                        state <= S_WAIT_DONE;
                    end else if (start_cnt == 8'(START_TIMEOUT - 1)) begin
                        bus.err_timeout <= 1'b1;
                        bus.busy        <= 1'b0;
                        state           <= S_IDLE;
                    end else begin
                        start_cnt <= start_cnt + 8'd1;
                    end
                end
                S_WAIT_DONE: begin
                    if (!bus.hex_busy) begin
                        bus.busy    <= 1'b0;
                        refresh_cnt <= '0;
                        state       <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_display_write_arbiter.sv
// Bench for display_write_arbiter: a 2-requester instance without refresh and a
// 4-requester instance with REFRESH_CYCLES=100, each driving a behavioural hex writer.
module tb_display_write_arbiter;
    logic clk   = 1'b0;
    logic rst_a = 1'b0;
    logic rst_b = 1'b0;
    always #5 clk = ~clk;

    display_write_arbiter_if #(.NUM_REQ(2)) ia ();
    display_write_arbiter_if #(.NUM_REQ(4)) ib ();

    display_write_arbiter #(.NUM_REQ(2), .REFRESH_CYCLES(0), .START_TIMEOUT(16)) u_a (
        .clk(clk), .rst(rst_a), .bus(ia)
    );
    display_write_arbiter #(.NUM_REQ(4), .REFRESH_CYCLES(100), .START_TIMEOUT(16)) u_b (
        .clk(clk), .rst(rst_b), .bus(ib)
    );

    typedef struct packed {
        logic [3:0]  ack;
        logic [15:0] data;
        logic [1:0]  owner;
    } exp_t;

    typedef struct {
        logic [3:0] valid;
        logic [1:0] grant;
    } vec_t;

    exp_t        qa[$];
    exp_t        qb[$];
    int          tests = 0;
    int          fails = 0;
    logic        wa_en = 1'b1;
    int          wa_cnt = 0;
    int          wb_cnt = 0;
    logic [15:0] wa_hold = '0;
    logic [15:0] wb_hold = '0;
    logic [15:0] bdata[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Writer model: busy rises two cycles after it sees the latch and stays up six cycles.
    always @(posedge clk or posedge rst_a) begin
        if (rst_a) wa_cnt <= 0;
        else if (wa_cnt != 0) wa_cnt <= wa_cnt - 1;
        else if (ia.hex_latch && wa_en) begin
            wa_cnt  <= 8;
            wa_hold <= ia.hex_data;
        end
    end
    assign ia.hex_busy = (wa_cnt >= 1) && (wa_cnt <= 6);

    always @(posedge clk or posedge rst_b) begin
        if (rst_b) wb_cnt <= 0;
        else if (wb_cnt != 0) wb_cnt <= wb_cnt - 1;
        else if (ib.hex_latch) begin
            wb_cnt  <= 8;
            wb_hold <= ib.hex_data;
        end
    end
    assign ib.hex_busy = (wb_cnt >= 1) && (wb_cnt <= 6);

    always @(negedge clk) begin : mon_a
        exp_t ea;
        if (!rst_a) begin
            if (ia.hex_latch) begin
                check("a_latch_while_hex_busy", 32'(ia.hex_busy), 32'd0);
                if (qa.size() == 0) check("a_unexpected_latch", 32'(qa.size()), 32'd1);
                else begin
                    ea = qa.pop_front();
                    check("a_ack", 32'(ia.req_ack), 32'(ea.ack));
                    check("a_data", 32'(ia.hex_data), 32'(ea.data));
                    check("a_owner", 32'(ia.owner), 32'(ea.owner));
                end
            end else if (ia.req_ack != '0) check("a_stray_ack", 32'(ia.req_ack), 32'd0);
            if (wa_cnt != 0) check("a_data_hold", 32'(ia.hex_data), 32'(wa_hold));
        end
    end

    always @(negedge clk) begin : mon_b
        exp_t eb;
        if (!rst_b) begin
            if (ib.hex_latch) begin
                check("b_latch_while_hex_busy", 32'(ib.hex_busy), 32'd0);
                if (qb.size() == 0) check("b_unexpected_latch", 32'(qb.size()), 32'd1);
                else begin
                    eb = qb.pop_front();
                    check("b_ack", 32'(ib.req_ack), 32'(eb.ack));
                    check("b_data", 32'(ib.hex_data), 32'(eb.data));
                    check("b_owner", 32'(ib.owner), 32'(eb.owner));
                end
            end else if (ib.req_ack != '0) check("b_stray_ack", 32'(ib.req_ack), 32'd0);
            if (wb_cnt != 0) check("b_data_hold", 32'(ib.hex_data), 32'(wb_hold));
        end
    end

    function automatic logic cond(input int inst, input int kind);
        case (kind)
            0:       return (inst == 0) ? ia.hex_latch : ib.hex_latch;
            1:       return (inst == 0) ? !ia.busy : !ib.busy;
            default: return (inst == 0) ? ia.hex_busy : ib.hex_busy;
        endcase
    endfunction

    // kind 0: hex_latch, 1: busy low, 2: hex_busy high; expiry counts as a failure.
    task automatic wait_for(input int inst, input int kind, input int budget, input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!cond(inst, kind) && n < budget);
        check(name, 32'(cond(inst, kind)), 32'd1);
    endtask

    function automatic logic [31:0] outs_a();
        return 32'({ia.hex_latch, ia.hex_data, ia.req_ack, ia.busy, ia.owner, ia.err_timeout});
    endfunction

    function automatic logic [31:0] outs_b();
        return 32'({ib.hex_latch, ib.hex_data, ib.req_ack, ib.busy, ib.owner, ib.err_timeout});
    endfunction

    initial begin
        vec_t tbl[10];
        int   n;
        tbl[0] = '{4'b0010, 2'd1};
        tbl[1] = '{4'b1010, 2'd3};
        tbl[2] = '{4'b1010, 2'd1};
        tbl[3] = '{4'b1010, 2'd3};
        tbl[4] = '{4'b1111, 2'd0};
        tbl[5] = '{4'b0101, 2'd2};
        tbl[6] = '{4'b0101, 2'd0};
        tbl[7] = '{4'b1000, 2'd3};
        tbl[8] = '{4'b0110, 2'd1};
        tbl[9] = '{4'b0001, 2'd0};
        bdata[0] = 16'hC0DE;
        bdata[1] = 16'h1234;
        bdata[2] = 16'hBEEF;
        bdata[3] = 16'h9876;

        ia.req_valid = '0;
        ia.req_data  = '0;
        ib.req_valid = '0;
        ib.req_data  = {bdata[3], bdata[2], bdata[1], bdata[0]};

        #1 rst_a = 1'b1; rst_b = 1'b1;
        #1 check("a_reset_outputs", outs_a(), 32'd0);
        check("b_reset_outputs", outs_b(), 32'd0);
        repeat (2) @(negedge clk);
        rst_a = 1'b0; rst_b = 1'b0;

        // Single write: one-cycle latency, one-cycle pulses, value held to the end.
        ia.req_data = {16'h0BAD, 16'h1234};
        qa.push_back('{ack: 4'b0001, data: 16'h1234, owner: 2'd0});
        ia.req_valid = 2'b01;
        @(negedge clk);
        check("a_latency", 32'(ia.hex_latch), 32'd1);
        ia.req_valid = '0;
        @(negedge clk);
        check("a_pulse_width", 32'({ia.hex_latch, ia.req_ack}), 32'd0);
        ia.req_valid = 2'b10;
        repeat (2) @(negedge clk);
        ia.req_valid = '0;
        wait_for(0, 1, 40, "a_done");
        check("a_busy_with_hex_busy", 32'(ia.hex_busy), 32'd0);
        check("a_data_kept", 32'(ia.hex_data), 32'h1234);
        repeat (4) @(negedge clk);

        // Fresh reset, then two requesters held valid alternate 0,1,0,1.
        rst_a = 1'b1;
        @(negedge clk);
        rst_a = 1'b0;
        ia.req_data = {16'h5555, 16'hAAAA};
        qa.push_back('{ack: 4'b0001, data: 16'hAAAA, owner: 2'd0});
        qa.push_back('{ack: 4'b0010, data: 16'h5555, owner: 2'd1});
        qa.push_back('{ack: 4'b0001, data: 16'hAAAA, owner: 2'd0});
        qa.push_back('{ack: 4'b0010, data: 16'h5555, owner: 2'd1});
        ia.req_valid = 2'b11;
        for (int k = 0; k < 4; k++) wait_for(0, 0, 60, "a_alt_latch");
        ia.req_valid = '0;
        wait_for(0, 1, 40, "a_alt_done");
        check("a_alt_all_seen", 32'(qa.size()), 32'd0);

        // Writer never answers: sticky timeout, then service resumes.
        wa_en = 1'b0;
        ia.req_data = {16'h7777, 16'h0F0F};
        qa.push_back('{ack: 4'b0001, data: 16'h0F0F, owner: 2'd0});
        ia.req_valid = 2'b01;
        wait_for(0, 0, 20, "a_to_latch");
        ia.req_valid = '0;
        repeat (10) @(negedge clk);
        check("a_to_pending", 32'({ia.err_timeout, ia.busy}), 32'b01);
        repeat (10) @(negedge clk);
        check("a_to_fired", 32'({ia.err_timeout, ia.busy}), 32'b10);
        wa_en = 1'b1;
        qa.push_back('{ack: 4'b0010, data: 16'h7777, owner: 2'd1});
        ia.req_valid = 2'b10;
        wait_for(0, 0, 20, "a_after_to_latch");
        ia.req_valid = '0;
        wait_for(0, 1, 40, "a_after_to_done");
        check("a_to_sticky", 32'(ia.err_timeout), 32'd1);

        // Reset while the writer is busy aborts at once; requester 0 wins afterwards.
        ia.req_data = {16'hD00D, 16'h4321};
        qa.push_back('{ack: 4'b0001, data: 16'h4321, owner: 2'd0});
        ia.req_valid = 2'b01;
        wait_for(0, 0, 20, "a_abort_latch");
        ia.req_valid = '0;
        wait_for(0, 2, 20, "a_abort_hex_busy");
        @(negedge clk);
        check("a_in_transfer", 32'(ia.busy), 32'd1);
        #2 rst_a = 1'b1;
        #1 check("a_async_abort", outs_a(), 32'd0);
        repeat (2) @(negedge clk);
        rst_a = 1'b0;
        ia.req_data = {16'hD00D, 16'hFACE};
        qa.push_back('{ack: 4'b0001, data: 16'hFACE, owner: 2'd0});
        ia.req_valid = 2'b11;
        wait_for(0, 0, 20, "a_post_reset_latch");
        ia.req_valid = '0;
        wait_for(0, 1, 40, "a_post_reset_done");
        check("a_queue_empty", 32'(qa.size()), 32'd0);

        // Four-requester round-robin table.
        for (int i = 0; i < 10; i++) begin
            qb.push_back('{ack: 4'(4'b0001 << tbl[i].grant), data: bdata[tbl[i].grant],
                           owner: tbl[i].grant});
            ib.req_valid = tbl[i].valid;
            wait_for(1, 0, 20, "b_tbl_latch");
            ib.req_valid = '0;
            wait_for(1, 1, 40, "b_tbl_done");
        end

        // Refresh: BEEF re-written after exactly 100 idle cycles, without ack.
        qb.push_back('{ack: 4'b0100, data: 16'hBEEF, owner: 2'd2});
        ib.req_valid = 4'b0100;
        wait_for(1, 0, 20, "b_beef_latch");
        ib.req_valid = '0;
        wait_for(1, 1, 40, "b_beef_done");
        qb.push_back('{ack: 4'b0000, data: 16'hBEEF, owner: 2'd2});
        n = 0;
        do begin @(negedge clk); n++; end while (!ib.hex_latch && n < 150);
        check("b_refresh_interval", 32'(n), 32'd100);
        wait_for(1, 1, 40, "b_refresh_done");

        // Request on the expiry cycle replaces the refresh and restarts the interval.
        repeat (99) @(negedge clk);
        qb.push_back('{ack: 4'b0001, data: 16'hC0DE, owner: 2'd0});
        ib.req_valid = 4'b0001;
        @(negedge clk);
        check("b_req_beats_refresh", 32'({ib.hex_latch, ib.req_ack}), 32'b10001);
        ib.req_valid = '0;
        wait_for(1, 1, 40, "b_req_done");
        qb.push_back('{ack: 4'b0000, data: 16'hC0DE, owner: 2'd0});
        n = 0;
        do begin @(negedge clk); n++; end while (!ib.hex_latch && n < 150);
        check("b_refresh_after_req", 32'(n), 32'd100);
        wait_for(1, 1, 40, "b_refresh2_done");
        check("b_queue_empty", 32'(qb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/display_write_arbiter.md
Name: display_write_arbiter

Overview:
- Shares one TM1637 4-digit hex display writer between NUM_REQ independent requesters using round-robin arbitration.
- Holds the granted 16-bit value stable on the writer's data input for the whole transfer. The writer samples its data input over many cycles during a transaction and does not latch it itself.
- Optionally re-issues the last displayed value periodically to recover the display after glitches.
- Sits between application logic and the hex display writer (data_latch / data_in / busy interface).

Parameters:
- NUM_REQ, 2, number of requesters; legal range 2..4.
- REFRESH_CYCLES, 0, idle cycles before the last value is re-written; 0 disables refresh.
- START_TIMEOUT, 16, cycles allowed for hex_busy to rise after hex_latch; legal range 2..255.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester write request; held until acked
- req_data  in  16*NUM_REQ  requester i value at bits [16i+15:16i]; 4 hex digits, MSB nibble leftmost
- req_ack  out  NUM_REQ  one-cycle grant/accept pulse to the granted requester
- hex_latch  out  1  one-cycle start pulse to the display writer's data_latch
- hex_data  out  16  value to the writer's data_in; stable from latch until the transfer completes
- hex_busy  in  1  writer busy flag
- busy  out  1  high while a transfer is in progress
- owner  out  2  index of the requester that owns the current or last transfer (0 for refresh-only history)
- err_timeout  out  1  sticky; set when hex_busy fails to rise in time

Behaviour:
- Reset (async, rst=1): state S_IDLE; hex_latch=0, hex_data=0, req_ack=0, busy=0, owner=0, err_timeout=0.
- Reset also clears internal state: last_grant=NUM_REQ-1 (so requester 0 wins first), refresh counter=0, have_value=0.
- rst asserted mid-transfer aborts immediately; the writer is not notified.
- S_IDLE:
  - If any req_valid bit is high, choose g as the first set bit searching from (last_grant+1) mod NUM_REQ upward with wrap.
  - Next edge: hex_data<=req_data[g]; req_ack[g]<=1; hex_latch<=1; busy<=1; owner<=g; last_grant<=g; have_value<=1; go to S_WAIT_START.
  - Latency from first valid cycle to ack/latch is 1 cycle.
  - Otherwise, if REFRESH_CYCLES!=0 and have_value=1, the refresh counter increments each idle cycle.
  - When the counter equals REFRESH_CYCLES-1: hex_latch<=1, busy<=1, hex_data unchanged, no ack, owner unchanged, counter<=0; go to S_WAIT_START.
  - A request in the same cycle the counter expires wins; the refresh is dropped and the counter clears.
- S_WAIT_START:
  - hex_latch and req_ack return to 0 after exactly one cycle.
  - On hex_busy=1, go to S_WAIT_DONE.
  - If START_TIMEOUT cycles elapse without hex_busy=1: err_timeout<=1, busy<=0, go to S_IDLE.
- S_WAIT_DONE: on hex_busy=0, busy<=0, refresh counter<=0, go to S_IDLE. A new grant may occur on the next cycle.
- hex_latch is never asserted while hex_busy=1 or busy=1. hex_data changes only at a grant edge.
- req_valid may drop without an ack (request withdrawn); no grant is made for it. Requests arriving during a transfer wait and are arbitrated in S_IDLE.
- Minimum spacing between consecutive hex_latch pulses is 3 cycles.

Test Plan:
- Reset, then req_valid=2'b01 with data0=16'h1234 -> req_ack[0] and hex_latch high for 1 cycle, one cycle later; hex_data=16'h1234 held until the model drops hex_busy; busy falls with it.
- Both requesters valid continuously (data0=16'hAAAA, data1=16'h5555) -> grants alternate 0,1,0,1; hex_data sequence AAAA,5555,AAAA,5555; each requester is acked once per transfer.
- NUM_REQ=4, valid=4'b1010 after last_grant=1 -> grant 3, then 1, then 3; requesters 0 and 2 are never acked.
- REFRESH_CYCLES=100, one write of 16'hBEEF then idle -> hex_latch re-pulses every 100 idle cycles plus transfer time, with hex_data=BEEF and no req_ack; a request on the expiry cycle is granted instead of the refresh.
- Model never raises hex_busy -> after START_TIMEOUT=16 cycles err_timeout=1 (sticky) and busy=0; the next request is still serviced.
- Assert rst during S_WAIT_DONE -> all outputs zero immediately (async); after release the first grant goes to requester 0.
